regfile_multiport_bypass: RTL and testbench

Parametrised multi-port integer register file for the superscalar core: replaces the fixed 32x32 single-write-port array. It provides NUM_WRITE write ports with same-cycle write-to-read bypass on all NUM_READ read ports, and register 0 is hard-wired to zero. It also holds a per-register pending scoreboard: decode sets pending bits and writeback clears them. It sits between decode/issue (read, reserve) and writeback (write).

---
 rtl/regfile_multiport_bypass.sv | 148 ++++++++++++++
 tb/tb_regfile_multiport_bypass.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport_bypass.sv
// -----------------------------------------------------------------------------
// regfile_multiport_bypass
//
// Multi-port integer register file with per-register pending scoreboard.
// Register 0 has no storage and always reads as zero. Every read port sees
// same-cycle writes (write-first bypass). When two write ports hit the same
// register, the highest port index wins. Decode reserves registers, which sets
// their pending bits. Writeback clears them. A flush drops every pending bit.
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset      in   asynchronous active-low reset: storage and scoreboard to 0
//   we         in   [NUM_WRITE]             per-port write enable
//   waddr      in   [NUM_WRITE*ADDR_WIDTH]  write address, port i at i*ADDR_WIDTH
//   wdata      in   [NUM_WRITE*DATA_WIDTH]  write data,    port i at i*DATA_WIDTH
//   raddr      in   [NUM_READ*ADDR_WIDTH]   read address per read port
//   rdata      out  [NUM_READ*DATA_WIDTH]   combinational bypassed read data
//   rpending   out  [NUM_READ]              pending bit of raddr, cleared by a
//                                           same-cycle write to that register
//   rsv_valid  in   [NUM_WRITE]             reserve request per port
//   rsv_addr   in   [NUM_WRITE*ADDR_WIDTH]  register to mark pending
//   flush      in   synchronous clear of all pending bits (reserves ignored)
//   busy_vec   out  [NUM_REGS]              raw registered pending vector
// -----------------------------------------------------------------------------
module regfile_multiport_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 4,
  parameter int NUM_WRITE  = 2,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_WRITE-1:0]            we,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rdata,
  output logic [NUM_READ-1:0]             rpending,
  input  logic [NUM_WRITE-1:0]            rsv_valid,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] rsv_addr,
  input  logic                            flush,
  output logic [NUM_REGS-1:0]             busy_vec
);

  // Unpacked views of the flattened port buses.
  logic [ADDR_WIDTH-1:0] waddr_a   [NUM_WRITE];
  logic [DATA_WIDTH-1:0] wdata_a   [NUM_WRITE];
  logic [ADDR_WIDTH-1:0] rsv_addr_a[NUM_WRITE];
  logic [ADDR_WIDTH-1:0] raddr_a   [NUM_READ];

  always_comb begin
    for (int i = 0; i < NUM_WRITE; i++) begin
      waddr_a[i]    = waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_a[i]    = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      rsv_addr_a[i] = rsv_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
    for (int r = 0; r < NUM_READ; r++) begin
      raddr_a[r] = raddr[r*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: registers 1..NUM_REGS-1 only. Index 0 has no flops.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

  // NOTE: this array is reset on purpose, because the architecture requires
  // every register to read 0 after reset. A plain RAM without reset would not
  // meet that, so this array maps to flops rather than a memory macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int k = 1; k < NUM_REGS; k++) begin
        // NOTE: ports are scanned in ascending order with non-blocking
        // assignments. The last assignment in the scan takes effect, so the
        // highest-indexed port wins a collision without extra priority logic.
        for (int i = 0; i < NUM_WRITE; i++) begin
          if (we[i] && waddr_a[i] == ADDR_WIDTH'(k)) begin
            regs[k] <= wdata_a[i];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending scoreboard. Writes clear bits first, then reserves set them, so a
  // same-cycle set wins over a clear. A flush overrides both. Bit 0 stays 0.
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  // NOTE: every always_comb output gets a full default first. Without it, a
  // path that does not assign the variable would infer a latch.
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < NUM_WRITE; i++) begin
      if (we[i]) pending_next[waddr_a[i]] = 1'b0;
    end
    if (flush) begin
      pending_next = '0;
    end else begin
      for (int i = 0; i < NUM_WRITE; i++) begin
        if (rsv_valid[i]) pending_next[rsv_addr_a[i]] = 1'b1;
      end
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_next;
  end

  assign busy_vec = pending;

  // ---------------------------------------------------------------------------
  // Read ports: stored value, overridden by the highest matching write port.
  // Address 0 never matches, so a write to 0 is neither stored nor bypassed.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_val [NUM_READ];
  logic                  rd_hit [NUM_READ];

  always_comb begin
    rdata    = '0;
    rpending = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      rd_val[r] = '0;
      rd_hit[r] = 1'b0;
      if (raddr_a[r] != '0) begin
        rd_val[r] = regs[raddr_a[r]];
        for (int i = 0; i < NUM_WRITE; i++) begin
          if (we[i] && waddr_a[i] == raddr_a[r]) begin
            rd_val[r] = wdata_a[i];
            rd_hit[r] = 1'b1;
          end
        end
      end
      rdata[r*DATA_WIDTH +: DATA_WIDTH] = rd_val[r];
      rpending[r] = pending[raddr_a[r]] & ~rd_hit[r];
    end
  end

endmodule

// File: tb/tb_regfile_multiport_bypass.sv
// -----------------------------------------------------------------------------
// tb_regfile_multiport_bypass
//
// Self-checking bench. A behavioural model (register array plus pending array)
// predicts every output on each falling edge. Directed sequences pin known
// literal values. Randomized traffic with a narrow address range then forces
// collisions, set/clear races and flushes. A mid-run asynchronous reset is
// checked before the next clock edge arrives.
// -----------------------------------------------------------------------------
module tb_regfile_multiport_bypass;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int AW = $clog2(NR);

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NWR-1:0]     we = '0;
  logic [NWR*AW-1:0]  waddr = '0;
  logic [NWR*DW-1:0]  wdata = '0;
  logic [NRD*AW-1:0]  raddr = '0;
  logic [NRD*DW-1:0]  rdata;
  logic [NRD-1:0]     rpending;
  logic [NWR-1:0]     rsv_valid = '0;
  logic [NWR*AW-1:0]  rsv_addr = '0;
  logic               flush = 1'b0;
  logic [NR-1:0]      busy_vec;

  regfile_multiport_bypass #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NRD), .NUM_WRITE(NWR)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rpending(rpending),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .flush(flush),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: architectural contents and pending flags.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m_mem  [NR];
  bit            m_pend [NR];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NR; k++) begin
        m_mem[k] = '0;
        m_pend[k] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        int a;
        a = int'(waddr[i*AW +: AW]);
        if (we[i] && a != 0) begin
          m_mem[a] = wdata[i*DW +: DW];
          m_pend[a] = 1'b0;
        end
      end
      if (flush) begin
        for (int k = 0; k < NR; k++) m_pend[k] = 1'b0;
      end else begin
        for (int i = 0; i < NWR; i++) begin
          int a;
          a = int'(rsv_addr[i*AW +: AW]);
          if (rsv_valid[i] && a != 0) m_pend[a] = 1'b1;
        end
      end
    end
  end

  // Expected read of one address given the current inputs and the model.
  function automatic logic [DW-1:0] exp_rdata(input int a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
    for (int i = 0; i < NWR; i++)
      if (we[i] && int'(waddr[i*AW +: AW]) == a) v = wdata[i*DW +: DW];
    return v;
  endfunction

  function automatic bit exp_rpend(input int a);
    for (int i = 0; i < NWR; i++)
      if (we[i] && int'(waddr[i*AW +: AW]) == a) return 1'b0;
    return m_pend[a];
  endfunction

  // Single compare process: inputs are stable and the model is settled here.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [NR-1:0] exp_busy;
      for (int k = 0; k < NR; k++) exp_busy[k] = m_pend[k];
      check("busy_vec", 64'(busy_vec), 64'(exp_busy));
      for (int r = 0; r < NRD; r++) begin
        int a;
        a = int'(raddr[r*AW +: AW]);
        check($sformatf("rdata[%0d] addr=%0d", r, a),
              64'(rdata[r*DW +: DW]), 64'(exp_rdata(a)));
        check($sformatf("rpending[%0d] addr=%0d", r, a),
              64'(rpending[r]), 64'(exp_rpend(a)));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; rsv_valid = '0; flush = 1'b0;
  endtask

  task automatic set_write(input int p, input int a, input logic [DW-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
  endtask

  task automatic set_rsv(input int p, input int a);
    rsv_valid[p] = 1'b1;
    rsv_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic read_all(input int a);
    for (int r = 0; r < NRD; r++) raddr[r*AW +: AW] = AW'(a);
  endtask

  // Lets combinational outputs settle before a literal check.
  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    cmp_en = 1'b1;
    idle();
    read_all(0);
    settle();
    check("reset busy_vec", 64'(busy_vec), 64'h0);

    // Basic write, bypass and stored value.
    set_write(0, 5, 32'hDEADBEEF);
    read_all(5);
    settle();
    check("bypass reg5", 64'(rdata[0 +: DW]), 64'hDEADBEEF);
    next_cycle(); idle(); settle();
    for (int r = 0; r < NRD; r++)
      check($sformatf("stored reg5 port%0d", r), 64'(rdata[r*DW +: DW]), 64'hDEADBEEF);

    // Write to register 0 is neither bypassed nor stored.
    next_cycle();
    set_write(0, 0, 32'h1234); read_all(0); settle();
    check("reg0 same cycle", 64'(rdata[0 +: DW]), 64'h0);
    next_cycle(); idle(); settle();
    check("reg0 next cycle", 64'(rdata[0 +: DW]), 64'h0);

    // Collision: highest port wins both bypass and storage.
    next_cycle();
    set_write(0, 7, 32'hAAAA0000); set_write(1, 7, 32'h5555FFFF);
    read_all(7); settle();
    check("collision bypass reg7", 64'(rdata[DW +: DW]), 64'h5555FFFF);
    next_cycle(); idle(); settle();
    check("collision stored reg7", 64'(rdata[3*DW +: DW]), 64'h5555FFFF);

    // Scoreboard reserve/clear timing.
    next_cycle();
    set_rsv(0, 9); read_all(9); settle();
    check("rsv same cycle rpending", 64'(rpending[0]), 64'h0);
    next_cycle(); idle(); settle();
    check("rsv N+1 busy9", 64'(busy_vec[9]), 64'h1);
    check("rsv N+1 rpending", 64'(rpending[2]), 64'h1);
    next_cycle(); settle();
    next_cycle();
    set_write(1, 9, 32'h00000099); settle();
    check("clr N+3 rpending", 64'(rpending[0]), 64'h0);
    check("clr N+3 rdata", 64'(rdata[0 +: DW]), 64'h99);
    check("clr N+3 busy9", 64'(busy_vec[9]), 64'h1);
    next_cycle(); idle(); settle();
    check("clr N+4 busy9", 64'(busy_vec[9]), 64'h0);

    // Set/clear race: the set wins, and the write still stores.
    next_cycle();
    set_write(0, 12, 32'h00C0FFEE); set_rsv(1, 12); read_all(12);
    next_cycle(); idle(); settle();
    check("race busy12", 64'(busy_vec[12]), 64'h1);
    check("race stored reg12", 64'(rdata[0 +: DW]), 64'h00C0FFEE);

    // Flush drops everything, including same-cycle reserves, but keeps writes.
    next_cycle();
    set_rsv(0, 3); set_rsv(1, 4);
    next_cycle(); idle(); set_rsv(0, 10);
    next_cycle(); idle(); settle();
    check("pre-flush busy", 64'(busy_vec), 64'(32'h0000_1418));
    flush = 1'b1; set_rsv(0, 11); set_write(1, 20, 32'h77);
    next_cycle(); idle(); read_all(20); settle();
    check("flush busy_vec", 64'(busy_vec), 64'h0);
    check("flush reg20", 64'(rdata[0 +: DW]), 64'h77);

    // Randomized traffic. Narrow addresses force collisions and races.
    for (int c = 0; c < 2000; c++) begin
      next_cycle();
      idle();
      for (int i = 0; i < NWR; i++) begin
        we[i] = 1'($urandom_range(0, 1));
        waddr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR-1))
                                                        : AW'($urandom_range(0, 7));
        wdata[i*DW +: DW] = $urandom;
        rsv_valid[i] = ($urandom_range(0, 2) == 0);
        rsv_addr[i*AW +: AW] = AW'($urandom_range(0, 9));
      end
      for (int r = 0; r < NRD; r++)
        raddr[r*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR-1))
                                                        : AW'($urandom_range(0, 9));
      flush = ($urandom_range(0, 31) == 0);

      if (c == 1000) begin
        // Asynchronous reset while contents are nonzero and the high phase is active.
        #2;
        reset = 1'b0;
        #1;
        check("async reset busy_vec", 64'(busy_vec), 64'h0);
        for (int r = 0; r < NRD; r++)
          check($sformatf("async reset rdata[%0d]", r), 64'(rdata[r*DW +: DW]), 64'h0);
        next_cycle();
        reset = 1'b1;
      end
    end

    next_cycle();
    idle();
    next_cycle();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
